// File: rtl/cache_mem_pkg.sv
// Shared constants for the cache memory-side port controller.
package cache_mem_pkg;
  localparam int LINE_WORDS  = 4;
  localparam int OFFSET_BITS = 2;
  localparam int ADDR_DEF    = 10;
  localparam int WIDTH_DEF   = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
endpackage

// File: rtl/cache_mem_port_ctrl_line_buffer.sv
// Refill line buffer: one word written per cycle at idx, cleared by reset.
module line_buffer
  import cache_mem_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [OFFSET_BITS-1:0]        idx,
  input  logic [WIDTH-1:0]              wdata,
  output logic [LINE_WORDS*WIDTH-1:0]   resp_line
);
  logic [LINE_WORDS-1:0][WIDTH-1:0] words;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     words <= '0;
    else if (we) words[idx] <= wdata;
  end

  assign resp_line = words;
endmodule

// File: rtl/cache_mem_port_ctrl.sv
// Memory-side port for the write-through data cache: 4-word block refill on
// read, single-word write-through store on write, one-cycle response pulse.
module cache_mem_port_ctrl
  import cache_mem_pkg::*;
#(
  parameter int ADDR  = ADDR_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  input  logic                        req_write,
  input  logic [ADDR-1:0]             req_addr,
  input  logic [WIDTH-1:0]            req_wdata,
  output logic                        req_ready,
  output logic                        resp_valid,
  output logic [LINE_WORDS*WIDTH-1:0] resp_line,
  output logic [WIDTH-1:0]            resp_word,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [ADDR-1:0]             mem_address,
  output logic [WIDTH-1:0]            mem_write_data,
  output logic [OFFSET_BITS-1:0]      mem_counter,
  input  logic                        mem_ready,
  input  logic [WIDTH-1:0]            mem_rdata
);
  localparam logic [OFFSET_BITS-1:0] LAST = OFFSET_BITS'(LINE_WORDS - 1);

  logic [1:0]                       state;
  logic [OFFSET_BITS-1:0]           cnt;
  logic [ADDR-1:0]                  addr_q;
  logic [WIDTH-1:0]                 wdata_q;
  logic [LINE_WORDS-1:0][WIDTH-1:0] buf_words, next_words, resp_line_q;
  logic [WIDTH-1:0]                 resp_word_q;

  line_buffer #(.WIDTH(WIDTH)) u_line (
    .clk       (clk),
    .rst       (rst),
    .we        (state == ST_READ),
    .idx       (cnt),
    .wdata     (mem_rdata),
    .resp_line (buf_words)
  );

  // Completed line as it will look once the final word lands; lets the
  // response registers load on the same edge the buffer finishes.
  always_comb begin
    next_words               = buf_words;
    next_words[LINE_WORDS-1] = mem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      resp_line_q <= '0;
      resp_word_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (req_valid) begin
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          cnt     <= '0;
          state   <= req_write ? ST_WRITE : ST_READ;
        end
        ST_READ: begin
          if (cnt != LAST) cnt <= cnt + 1'b1;
          else if (mem_ready) begin
            resp_line_q <= next_words;
            resp_word_q <= next_words[addr_q[OFFSET_BITS-1:0]];
            state       <= ST_DONE;
          end
        end
        ST_WRITE: state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Responses are held in their own registers so writes and in-flight
  // refills never disturb the last completed line.
  assign resp_line  = resp_line_q;
  assign resp_word  = resp_word_q;
  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_DONE);
  assign mem_read   = (state == ST_READ);
  assign mem_write  = (state == ST_WRITE);

  always_comb begin
    mem_address    = '0;
    mem_write_data = '0;
    mem_counter    = '0;
    if (mem_read) begin
      mem_address = {addr_q[ADDR-1:OFFSET_BITS], OFFSET_BITS'(0)};
      mem_counter = cnt;
    end else if (mem_write) begin
      mem_address    = addr_q;
      mem_write_data = wdata_q;
    end
  end
endmodule

// File: tb/tb_cache_mem_port_ctrl.sv
// Scoreboard bench for cache_mem_port_ctrl with a word-addressed memory stub.
module tb_cache_mem_port_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_write;
  logic [9:0]   req_addr;
  logic [31:0]  req_wdata;
  logic         req_ready, resp_valid;
  logic [127:0] resp_line;
  logic [31:0]  resp_word;
  logic         mem_read, mem_write;
  logic [9:0]   mem_address;
  logic [31:0]  mem_write_data;
  logic [1:0]   mem_counter;
  logic         mem_ready;
  logic [31:0]  mem_rdata;

  cache_mem_port_ctrl #(.ADDR(10), .WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_line(resp_line), .resp_word(resp_word),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_counter(mem_counter),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // memory stub
  logic [31:0] mem [0:1023];
  int stall_req = 0;
  int stall_used = 0;
  assign mem_rdata = mem_read ? mem[mem_address + 10'(mem_counter)] : 32'h0;
  assign mem_ready = mem_read && mem_counter == 2'd3 && stall_used >= stall_req;
  always @(negedge clk) if (mem_write) mem[mem_address] <= mem_write_data;
  always @(posedge clk) begin
    if (!mem_read) stall_used <= 0;
    else if (mem_counter == 2'd3 && !mem_ready) stall_used <= stall_used + 1;
  end

  typedef struct {
    logic         is_wr;
    logic [127:0] line;
    logic [31:0]  word;
    int           lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   overlap = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // monitor: records accepts, pops and compares on every response pulse
  always @(negedge clk) begin
    if (mem_read && mem_write) overlap++;
    if (resp_valid) begin
      if (exp_q.size() == 0 || acc_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_resp: got resp_valid=1 want no response (cycle %0d)", cyc);
      end else begin
        exp_t e;
        int   a;
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        check("resp_latency", 128'(cyc - a), 128'(e.lat));
        check(e.is_wr ? "wr_resp_line" : "rd_resp_line", resp_line, e.line);
        check(e.is_wr ? "wr_resp_word" : "rd_resp_word", 128'(resp_word), 128'(e.word));
      end
    end
    if (rst) acc_q.delete();
    else if (req_valid && req_ready) acc_q.push_back(cyc);
  end

  task automatic issue(input logic wr, input logic [9:0] a, input logic [31:0] d,
                       input logic [127:0] el, input logic [31:0] ew, input int lat,
                       input bit push);
    int n;
    exp_t e;
    if (push) begin
      e.is_wr = wr; e.line = el; e.word = ew; e.lat = lat;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 50);
    if (!req_ready) begin total++; bad++; $display("FAIL accept_timeout: got req_ready=0 want 1"); end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // watch the transfer until resp_valid, capturing memory-side activity
  task automatic wait_done(output logic [7:0] seq, output int rcnt, output int c3,
                           output int wcnt, output logic [9:0] waddr, output logic [31:0] wdat);
    int n;
    seq = '0; rcnt = 0; c3 = 0; wcnt = 0; waddr = '0; wdat = '0;
    n = 0;
    forever begin
      @(negedge clk); n++;
      if (resp_valid) break;
      if (n > 30) begin
        total++; bad++; $display("FAIL resp_timeout: got resp_valid=0 want 1");
        break;
      end
      if (mem_read) begin
        seq = {seq[5:0], mem_counter};
        rcnt++;
        if (mem_counter == 2'd3) c3++;
      end
      if (mem_write) begin wcnt++; waddr = mem_address; wdat = mem_write_data; end
    end
  endtask

  function automatic logic [31:0] av(input int i); return 32'hA0A0_0000 + i; endfunction
  function automatic logic [31:0] bv(input int i); return 32'hB0B0_0000 + i; endfunction

  logic [127:0] line_a, line_b, line_b2, line_a2;
  logic [7:0]   seq;
  int           rcnt, c3, wcnt;
  logic [9:0]   waddr;
  logic [31:0]  wdat;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      mem[10'h40 + i] = av(i);
      mem[10'h104 + i] = bv(i);
    end
    line_a  = {av(3), av(2), av(1), av(0)};
    line_b  = {bv(3), bv(2), 32'hDEADBEEF, bv(0)};
    line_b2 = {bv(3), 32'h12345678, 32'hDEADBEEF, bv(0)};
    line_a2 = {32'h5555AAAA, av(2), av(1), av(0)};

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 128'(req_ready), 128'(1));
    check("rst_ctrl_outs", 128'({resp_valid, mem_read, mem_write, mem_counter}), 128'(0));
    check("rst_mem_bus", 128'({mem_address, mem_write_data}), 128'(0));
    check("rst_resp", {resp_line[95:0], resp_word}, 128'(0));
    @(negedge clk); rst = 1'b0;

    // refill of 0x40 block, requested word 2
    issue(1'b0, 10'h42, 32'h0, line_a, av(2), 5, 1'b1);
    wait_done(seq, rcnt, c3, wcnt, waddr, wdat);
    check("rd_counter_seq", 128'(seq), 128'(8'h1B));
    check("rd_cycles", 128'(rcnt), 128'(4));

    // write-through store; response leaves the previous line alone
    issue(1'b1, 10'h105, 32'hDEADBEEF, line_a, av(2), 2, 1'b1);
    wait_done(seq, rcnt, c3, wcnt, waddr, wdat);
    check("wr_cycles", 128'(wcnt), 128'(1));
    check("wr_addr", 128'(waddr), 128'(10'h105));
    check("wr_data", 128'(wdat), 128'(32'hDEADBEEF));
    check("wr_no_read", 128'(rcnt), 128'(0));

    issue(1'b0, 10'h104, 32'h0, line_b, bv(0), 5, 1'b1);
    wait_done(seq, rcnt, c3, wcnt, waddr, wdat);

    // memory withholds ready for two extra cycles at counter 3
    stall_req = 2;
    issue(1'b0, 10'h43, 32'h0, line_a, av(3), 7, 1'b1);
    wait_done(seq, rcnt, c3, wcnt, waddr, wdat);
    check("stall_c3_cycles", 128'(c3), 128'(3));
    stall_req = 0;

    // reset in the middle of a refill
    issue(1'b0, 10'h40, 32'h0, '0, '0, 0, 1'b0);
    begin
      int n;
      n = 0;
      while (!(mem_read && mem_counter == 2'd2) && n < 20) begin @(negedge clk); n++; end
      check("abort_reached_cnt2", 128'(mem_counter), 128'(2));
    end
    rst = 1'b1;
    #1;
    check("abort_mem_read", 128'(mem_read), 128'(0));
    check("abort_req_ready", 128'(req_ready), 128'(1));
    check("abort_resp_line", resp_line, 128'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    issue(1'b0, 10'h41, 32'h0, line_a, av(1), 5, 1'b1);
    wait_done(seq, rcnt, c3, wcnt, waddr, wdat);

    // back-to-back alternating traffic with req_valid held high
    begin
      logic        bw [5];
      logic [9:0]  ba [5];
      logic [31:0] bd [5];
      int          acc [5];
      int          n;
      exp_t        e;
      bw = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      ba = '{10'h40, 10'h106, 10'h106, 10'h43, 10'h42};
      bd = '{32'h0, 32'h12345678, 32'h0, 32'h5555AAAA, 32'h0};
      e.is_wr = 0; e.line = line_a;  e.word = av(0);        e.lat = 5; exp_q.push_back(e);
      e.is_wr = 1; e.line = line_a;  e.word = av(0);        e.lat = 2; exp_q.push_back(e);
      e.is_wr = 0; e.line = line_b2; e.word = 32'h12345678; e.lat = 5; exp_q.push_back(e);
      e.is_wr = 1; e.line = line_b2; e.word = 32'h12345678; e.lat = 2; exp_q.push_back(e);
      e.is_wr = 0; e.line = line_a2; e.word = av(2);        e.lat = 5; exp_q.push_back(e);
      @(posedge clk); #1;
      req_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
        req_write = bw[k]; req_addr = ba[k]; req_wdata = bd[k];
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready && n < 50);
        acc[k] = cyc;
        @(posedge clk); #1;
      end
      req_valid = 1'b0;
      for (int k = 1; k < 5; k++)
        check("b2b_accept_gap", 128'(acc[k] - acc[k-1]), 128'(bw[k-1] ? 3 : 6));
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
      repeat (3) @(negedge clk);
    end

    check("sb_drained", 128'(exp_q.size()), 128'(0));
    check("rd_wr_overlap", 128'(overlap), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
